// File: rtl/alu_nibble_serial_if.sv
// ---------------------------------------------------------------------------
// alu_nibble_serial_if
//   Request/response bundle for the nibble-serial 74181-style ALU.
//
//   Parameter
//     WIDTH      operand/result width in bits (multiple of 4, 4..64)
//
//   Signals
//     a, b       operands                        (master -> slave)
//     s          4-bit function select           (master -> slave)
//     m          mode, 1 = logic, 0 = arithmetic (master -> slave)
//     cn_b       carry-in, active-low            (master -> slave)
//     in_valid   request present                 (master -> slave)
//     in_ready   request accepted when both high (slave  -> master)
//     f          result                          (slave  -> master)
//     cn_out_b   carry-out, active-low           (slave  -> master)
//     aeb        AND of all result bits          (slave  -> master)
//     x_b        group propagate, active-low     (slave  -> master)
//     out_valid  result present                  (slave  -> master)
//     out_ready  result consumed when both high  (master -> slave)
//     acc_sel    use last delivered f as operand A (only with ALU_ACCUM_EN)
//
//   Configuration macro: ALU_ACCUM_EN adds acc_sel.
// ---------------------------------------------------------------------------
interface alu_nibble_serial_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             cn_b;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] f;
    logic             cn_out_b;
    logic             aeb;
    logic             x_b;
    logic             out_valid;
    logic             out_ready;
`ifdef ALU_ACCUM_EN
    logic             acc_sel;

    modport master (
        output a, b, s, m, cn_b, in_valid, out_ready, acc_sel,
        input  in_ready, f, cn_out_b, aeb, x_b, out_valid
    );

    modport slave (
        input  a, b, s, m, cn_b, in_valid, out_ready, acc_sel,
        output in_ready, f, cn_out_b, aeb, x_b, out_valid
    );
`else
    modport master (
        output a, b, s, m, cn_b, in_valid, out_ready,
        input  in_ready, f, cn_out_b, aeb, x_b, out_valid
    );

    modport slave (
        input  a, b, s, m, cn_b, in_valid, out_ready,
        output in_ready, f, cn_out_b, aeb, x_b, out_valid
    );
`endif
endinterface

// File: rtl/alu_nibble_serial.sv
// ---------------------------------------------------------------------------
// alu_nibble_serial
//   74181-style ALU evaluated one 4-bit nibble per clock, LSB nibble first.
//   A request is captured in IDLE, the WIDTH/4 nibbles are processed in BUSY
//   with the ripple carry held in a register between nibbles, and the result
//   is presented in DONE until the consumer takes it.
//
//   Parameter
//     WIDTH      operand/result width in bits (multiple of 4, 4..64)
//
//   Ports
//     clk        single clock, rising edge
//     rst_n      synchronous active-low reset
//     bus        alu_nibble_serial_if.slave: operands, select, mode, carry-in,
//                in_valid/in_ready, f, cn_out_b, aeb, x_b, out_valid/out_ready
//
//   Configuration macro: ALU_ACCUM_EN
//     When defined, bus.acc_sel = 1 at acceptance replaces operand A with the
//     last delivered result (accumulator, cleared by reset).
// ---------------------------------------------------------------------------
module alu_nibble_serial #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_nibble_serial_if.slave    bus
);

    localparam int N     = WIDTH / 4;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Control / output registers
    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] f_q;
    logic             cn_out_b_q;
    logic             aeb_q;
    logic             x_b_q;
    logic             carry_q;
    logic             eall_q;     // running AND of E over nibbles done so far
    logic [CNT_W-1:0] cnt_q;

    // Captured request; operands shift right so the active nibble is [3:0]
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       s_q;
    logic             m_q;

    // Nibble datapath
    logic [3:0]       nib_e;
    logic [3:0]       nib_d;
    logic [3:0]       nib_f;
    logic             cy;
    logic             nib_cout;
    logic [WIDTH-1:0] f_d;
    logic             eall_d;
    logic             last_nib;

    logic             accept;
    logic [WIDTH-1:0] op_a_d;

`ifdef ALU_ACCUM_EN
    logic [WIDTH-1:0] acc_q;
    assign op_a_d = bus.acc_sel ? acc_q : bus.a;
`else
    assign op_a_d = bus.a;
`endif

    // in_ready_q is only ever high in IDLE; rst_n gating keeps reset cycles
    // from loading the operand registers.
    assign accept   = rst_n && (state_q == IDLE) && bus.in_valid && in_ready_q;
    assign last_nib = (cnt_q == CNT_W'(N - 1));

    // One nibble of the 74181 equations; cy ripples across the four bits
    // starting from the carry left over by the previous nibble.
    always_comb begin
        nib_e = '0;
        nib_d = '0;
        nib_f = '0;
        cy    = carry_q;
        for (int i = 0; i < 4; i++) begin
            nib_e[i] = ~((a_q[i] & b_q[i] & s_q[3]) | (a_q[i] & ~b_q[i] & s_q[2]));
            nib_d[i] = ~(a_q[i] | (~b_q[i] & s_q[1]) | (b_q[i] & s_q[0]));
            nib_f[i] = nib_e[i] ^ nib_d[i] ^ (cy | m_q);
            // Carry chain runs in logic mode too, so cn_out_b stays meaningful.
            cy       = ~nib_d[i] & (cy | ~nib_e[i]);
        end
        nib_cout = cy;
    end

    always_comb begin
        f_d               = f_q;
        f_d[4*cnt_q +: 4] = nib_f;
        eall_d            = eall_q & (&nib_e);
    end

    // Operand capture and per-nibble shift (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= op_a_d;
            b_q <= bus.b;
            s_q <= bus.s;
            m_q <= bus.m;
        end else if (state_q == BUSY) begin
            a_q <= a_q >> 4;
            b_q <= b_q >> 4;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            cn_out_b_q  <= 1'b0;
            aeb_q       <= 1'b0;
            x_b_q       <= 1'b0;
            carry_q     <= 1'b0;
            eall_q      <= 1'b0;
            cnt_q       <= '0;
`ifdef ALU_ACCUM_EN
            acc_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // First cycle out of reset raises in_ready here.
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                        carry_q    <= ~bus.cn_b;
                        eall_q     <= 1'b1;
                        cnt_q      <= '0;
                    end
                end

                BUSY: begin
                    f_q     <= f_d;
                    carry_q <= nib_cout;
                    eall_q  <= eall_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_nib) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        cn_out_b_q  <= ~nib_cout;
                        x_b_q       <= ~eall_d;
                        aeb_q       <= &f_d;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
`ifdef ALU_ACCUM_EN
                        acc_q       <= f_q;
`endif
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign bus.cn_out_b  = cn_out_b_q;
    assign bus.aeb       = aeb_q;
    assign bus.x_b       = x_b_q;

endmodule

// File: tb/tb_alu_nibble_serial.sv
// ---------------------------------------------------------------------------
// tb_alu_nibble_serial
//   Directed vectors with hand-computed results for alu_nibble_serial
//   (WIDTH = 16): add, add with overflow, A-B-1 with both carry-ins, logic
//   XOR, DONE back-pressure and reset in the middle of BUSY.
// ---------------------------------------------------------------------------
module tb_alu_nibble_serial;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_nibble_serial_if #(.WIDTH(WIDTH)) ifc();

    alu_nibble_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request, wait (bounded) for acceptance, then scramble the
    // inputs so any late sampling by the DUT shows up in the result.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [3:0] s, input logic m, input logic cn_b);
        int t;
        @(negedge clk);
        ifc.a        = a;
        ifc.b        = b;
        ifc.s        = s;
        ifc.m        = m;
        ifc.cn_b     = cn_b;
        ifc.in_valid = 1'b1;
        t = 0;
        while (!ifc.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", (t < 20), 1'b1);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.a        = ~a;
        ifc.b        = ~b;
        ifc.s        = ~s;
        ifc.m        = ~m;
        ifc.cn_b     = ~cn_b;
    endtask

    // Called #1 after the accepting edge; the accept cycle counts as 1.
    task automatic wait_done(input string tag);
        int lat;
        lat = 1;
        while (!ifc.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, N + 1);
    endtask

    task automatic expect_result(input string tag, input logic [WIDTH-1:0] f,
                                 input logic cn_out_b, input logic aeb, input logic x_b);
        check({tag, "_f"},        ifc.f,        f);
        check({tag, "_cn_out_b"}, ifc.cn_out_b, cn_out_b);
        check({tag, "_aeb"},      ifc.aeb,      aeb);
        check({tag, "_x_b"},      ifc.x_b,      x_b);
    endtask

    task automatic release_result(input string tag);
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        check({tag, "_rel_out_valid"}, ifc.out_valid, 1'b0);
        check({tag, "_rel_in_ready"},  ifc.in_ready,  1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        ifc.a         = '0;
        ifc.b         = '0;
        ifc.s         = '0;
        ifc.m         = 1'b0;
        ifc.cn_b      = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
`ifdef ALU_ACCUM_EN
        ifc.acc_sel   = 1'b0;
`endif

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  ifc.in_ready,  1'b0);
        check("rst_out_valid", ifc.out_valid, 1'b0);
        check("rst_f",         ifc.f,         16'h0000);
        check("rst_cn_out_b",  ifc.cn_out_b,  1'b0);
        check("rst_aeb",       ifc.aeb,       1'b0);
        check("rst_x_b",       ifc.x_b,       1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_rel_in_ready_low", ifc.in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rst_rel_in_ready_high", ifc.in_ready, 1'b1);

        // A plus B: 0x1234 + 0x1111
        send(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1);
        wait_done("add");
        expect_result("add", 16'h2345, 1'b1, 1'b0, 1'b1);
        // Back-pressure: DONE held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hold_f",         ifc.f,         16'h2345);
            check("hold_in_ready",  ifc.in_ready,  1'b0);
            check("hold_out_valid", ifc.out_valid, 1'b1);
        end
        release_result("add");

        // A plus B with carry out of the top nibble
        send(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        wait_done("add_ovf");
        expect_result("add_ovf", 16'h0000, 1'b0, 1'b0, 1'b1);
        release_result("add_ovf");

        // A minus B minus 1 with A == B
        send(16'h0005, 16'h0005, 4'b0110, 1'b0, 1'b1);
        wait_done("sub1");
        expect_result("sub1", 16'hFFFF, 1'b1, 1'b1, 1'b0);
        release_result("sub1");

        // A minus B with carry-in asserted
        send(16'h0005, 16'h0005, 4'b0110, 1'b0, 1'b0);
        wait_done("sub");
        expect_result("sub", 16'h0000, 1'b0, 1'b0, 1'b0);
        release_result("sub");

        // Logic mode XOR; carry chain still reflects A + ~B (no carry out)
        send(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1);
        wait_done("xor");
        expect_result("xor", 16'h0FF0, 1'b1, 1'b0, 1'b1);
        release_result("xor");

        // Reset during the second BUSY cycle discards the request
        send(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        seen = ifc.out_valid;
        @(posedge clk);
        #1;
        seen  = seen | ifc.out_valid;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        seen = seen | ifc.out_valid;
        check("midrst_in_ready", ifc.in_ready, 1'b0);
        check("midrst_f",        ifc.f,        16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            seen = seen | ifc.out_valid;
        end
        check("midrst_no_out_valid", seen,         1'b0);
        check("midrst_in_ready_up",  ifc.in_ready, 1'b1);

        // Next request after the aborted one computes correctly
        send(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        wait_done("post_rst");
        expect_result("post_rst", 16'h0100, 1'b1, 1'b0, 1'b1);
        release_result("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_nibble_serial.md
ALU_NIBBLE_SERIAL -- requirements
Module: alu_nibble_serial

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand width in bits; multiple of 4, range 4..64.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have ports: a  in  WIDTH  operand A; b  in  WIDTH  operand B.
REQ-005 SHALL have ports: s  in  4  function select; m  in  1  mode (1 = logic, 0 = arithmetic).
REQ-006 SHALL have port: cn_b  in  1  carry-in, active-low.
REQ-007 SHALL have ports: in_valid  in  1  request present; in_ready  out  1  request accepted when both high.
REQ-008 SHALL have ports: f  out  WIDTH  result; cn_out_b  out  1  carry-out, active-low; aeb  out  1  AND of all f bits; x_b  out  1  group propagate, active-low.
REQ-009 SHALL have ports: out_valid  out  1  result present; out_ready  in  1  result consumed when both high.

Function
REQ-010 SHALL use these per-bit terms: E[i] = ~((a&b&s3)|(a&~b&s2)); D[i] = ~(a|(~b&s1)|(b&s0)).
REQ-011 SHALL compute internal carry c[0] = ~cn_b and c[i+1] = ~D[i] & (c[i] | ~E[i]).
REQ-012 SHALL compute f[i] = E[i] ^ D[i] ^ (c[i] | m).
REQ-013 SHALL set cn_out_b = ~c[WIDTH], aeb = &f, and x_b = ~&E over all WIDTH bits.
REQ-014 SHALL process one 4-bit nibble per cycle, LSB nibble first, holding the carry between nibbles in a register.
REQ-015 SHALL use states IDLE, BUSY, DONE.
REQ-016 SHALL transition IDLE->BUSY on in_valid & in_ready, capturing a, b, s, m and cn_b into internal registers.
REQ-017 SHALL, in BUSY, process nibble k in the k-th BUSY cycle (k = 0..N-1, N = WIDTH/4), then go to DONE.
REQ-018 SHALL transition DONE->IDLE on out_ready; otherwise hold DONE with all outputs stable.
REQ-019 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-020 SHALL give latency N+1 cycles from the accepting edge to out_valid high; throughput is one request per N+2 cycles at best.
REQ-021 SHALL ignore input changes after capture; a, b, s, m and cn_b are don't-care outside the accepting cycle.
REQ-022 SHALL, when m = 1, keep cn_out_b computed from the carry chain (it is not forced), matching the per-bit equations.
REQ-023 SHALL, for WIDTH = 4, spend exactly one cycle in BUSY.

Reset
REQ-024 SHALL, on rst_n low at a clock edge, enter IDLE and clear f, cn_out_b, aeb, x_b, out_valid and the carry register to 0.
REQ-025 SHALL, if reset occurs mid-BUSY or in DONE, discard the request with no output and no out_valid pulse.
REQ-026 SHALL hold in_ready low during reset cycles and raise it in the first cycle after rst_n is high.

Configuration
REQ-027 SHALL support macro ALU_ACCUM_EN; when defined, SHALL add port acc_sel (in, 1).
REQ-028 SHALL, with ALU_ACCUM_EN and acc_sel = 1 at acceptance, use the last delivered f as operand A; the accumulator resets to 0.
REQ-029 SHALL, without ALU_ACCUM_EN, have no acc_sel port and always use port a as operand A.

Verification
REQ-030 SHALL cover: WIDTH=16, s=1001, m=0, cn_b=1, a=0x1234, b=0x1111 -> f=0x2345, cn_out_b=1, out_valid 5 cycles after accept.
REQ-031 SHALL cover: s=1001, m=0, cn_b=1, a=0xFFFF, b=0x0001 -> f=0x0000, cn_out_b=0, aeb=0.
REQ-032 SHALL cover: s=0110, m=0, cn_b=1, a=b=0x0005 -> f=0xFFFF, aeb=1; repeated with cn_b=0 -> f=0x0000, aeb=0.
REQ-033 SHALL cover: s=0110, m=1, a=0xF0F0, b=0xFF00 -> f=0x0FF0.
REQ-034 SHALL cover: out_ready held low for 3 cycles in DONE -> f stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover: rst_n low during the 2nd BUSY cycle -> IDLE, out_valid never asserted, next request is computed correctly.
